// File: rtl/ft601_burst_buf.sv
// FT601 receive burst buffer: bursts fill banks round-robin and are
// handed to the reader whole, oldest first, with length and last marker.
module ft601_burst_buf #(
  parameter int DATA_W     = 36,
  parameter int BANK_DEPTH = 4096,
  parameter int NUM_BANKS  = 2,
  parameter int CNT_W      = $clog2(BANK_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         wr_en,
  output logic                         wr_ready,
  output logic                         wr_afull,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rd_valid,
  input  logic                         rd_en,
  output logic                         rd_last,
  output logic [CNT_W-1:0]             rd_len,
  output logic [$clog2(NUM_BANKS+1)-1:0] banks_ready,
  output logic                         overflow
);

  localparam int AW = $clog2(BANK_DEPTH);
  localparam int BW = $clog2(NUM_BANKS);
  localparam int RW = $clog2(NUM_BANKS + 1);
  localparam int MD = NUM_BANKS * BANK_DEPTH;

  localparam logic [BW-1:0]    LAST_BANK = BW'(NUM_BANKS - 1);
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(BANK_DEPTH);
  localparam logic [CNT_W-1:0] AFULL     = CNT_W'(BANK_DEPTH - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  typedef enum logic [1:0] {
    FREE,
    FILLING,
    READY,
    DRAINING
  } bank_st_t;

  bank_st_t          bstate [NUM_BANKS];
  logic [CNT_W-1:0]  blen   [NUM_BANKS];
  logic [DATA_W-1:0] mem    [MD];
  logic [DATA_W-1:0] ram_q;

  logic [BW-1:0]    wr_bank;
  logic [BW-1:0]    wr_bank_nx;
  logic [BW-1:0]    rd_bank;
  logic [BW-1:0]    rd_bank_nx;
  logic [BW-1:0]    ready_bank;
  bank_st_t         ready_st;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] rd_ptr;
  logic [CNT_W-1:0] rd_ptr_nx;
  logic [BW+AW-1:0] waddr;
  logic [BW+AW-1:0] raddr;

  logic accept;
  logic commit_full;
  logic commit;
  logic xfer;
  logic rel;
  logic load;
  logic advance;

  assign accept      = wr_en && wr_ready;
  assign commit_full = accept && (wr_cnt == AFULL);
  assign commit      = commit_full || (!wr_en && wr_cnt != '0);
  assign xfer        = rd_valid && rd_en;
  assign rel         = xfer && rd_last;
  assign load        = !rd_valid && (bstate[rd_bank] == READY);
  assign wr_afull    = (wr_cnt >= AFULL);

  assign wr_bank_nx = (wr_bank == LAST_BANK) ? '0 : wr_bank + BW'(1);
  assign rd_bank_nx = (rd_bank == LAST_BANK) ? '0 : rd_bank + BW'(1);

  // rd_ptr is the index held in ram_q; step it whenever ram_q is consumed
  assign advance   = load || (xfer && !rd_last);
  assign rd_ptr_nx = advance ? rd_ptr + ONE : rd_ptr;

  assign waddr = {wr_bank, wr_cnt[AW-1:0]};
  // on release, prefetch word 0 of the next bank so the gap is one cycle
  assign raddr = rel ? {rd_bank_nx, {AW{1'b0}}}
                     : {rd_bank, rd_ptr_nx[AW-1:0]};

  // Next-cycle state of the bank the writer will target
  always_comb begin
    ready_bank = commit ? wr_bank_nx : wr_bank;
    ready_st   = bstate[ready_bank];
    if (rel && ready_bank == rd_bank) begin
      ready_st = FREE;
    end
  end

  // Writer: fill the open bank, advance on burst end or full bank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank  <= '0;
      wr_cnt   <= '0;
      wr_ready <= 1'b1;
      overflow <= 1'b0;
    end else begin
      wr_ready <= (ready_st == FREE) || (ready_st == FILLING);
      if (wr_en && !wr_ready) begin
        overflow <= 1'b1;
      end
      if (commit) begin
        wr_bank <= wr_bank_nx;
        wr_cnt  <= '0;
      end else if (accept) begin
        wr_cnt <= wr_cnt + ONE;
      end
    end
  end

  // Bank table: lifecycle and latched burst length per bank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        bstate[i] <= FREE;
        blen[i]   <= '0;
      end
    end else begin
      if (accept && wr_cnt == '0) begin
        bstate[wr_bank] <= FILLING;
      end
      if (commit) begin
        bstate[wr_bank] <= READY;
        blen[wr_bank]   <= commit_full ? FULL : wr_cnt;
      end
      if (load) begin
        bstate[rd_bank] <= DRAINING;
      end
      if (rel) begin
        bstate[rd_bank] <= FREE;
      end
    end
  end

  // Count of banks committed and not yet fully drained
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      banks_ready <= '0;
    end else begin
      case ({commit, rel})
        2'b10:   banks_ready <= banks_ready + RW'(1);
        2'b01:   banks_ready <= banks_ready - RW'(1);
        default: banks_ready <= banks_ready;
      endcase
    end
  end

  // Storage: one write port and one registered read port
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[waddr] <= wr_data;
    end
    ram_q <= mem[raddr];
  end

  // Reader: FWFT output stage walking one bank at a time
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_len   <= '0;
      rd_data  <= '0;
      rd_ptr   <= '0;
      rd_bank  <= '0;
    end else begin
      rd_ptr <= rd_ptr_nx;
      if (load) begin
        rd_valid <= 1'b1;
        rd_data  <= ram_q;
        rd_len   <= blen[rd_bank];
        rd_last  <= (blen[rd_bank] == ONE);
      end else if (rel) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
        rd_bank  <= rd_bank_nx;
        rd_ptr   <= '0;
      end else if (xfer) begin
        rd_data <= ram_q;
        rd_last <= (rd_ptr == rd_len - ONE);
      end
    end
  end

endmodule

// File: tb/tb_ft601_burst_buf.sv
// Bench for ft601_burst_buf: directed scenarios plus random traffic
// checked against a queue-based burst model.
module tb_ft601_burst_buf;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int NB    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int RW    = $clog2(NB + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] wr_data = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          wr_ready;
  logic          wr_afull;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_last;
  logic [CW-1:0] rd_len;
  logic [RW-1:0] banks_ready;
  logic          overflow;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] open_q[$];
  logic [DW-1:0] exp_d[$];
  bit            exp_l[$];
  int            exp_n[$];
  int            m_occ = 0;
  int            m_banks = 0;
  bit            m_ready = 1'b1;
  bit            m_ovf = 1'b0;

  ft601_burst_buf #(
    .DATA_W(DW),
    .BANK_DEPTH(DEPTH),
    .NUM_BANKS(NB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .wr_ready(wr_ready),
    .wr_afull(wr_afull),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .rd_en(rd_en),
    .rd_last(rd_last),
    .rd_len(rd_len),
    .banks_ready(banks_ready),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    open_q.delete();
    exp_d.delete();
    exp_l.delete();
    exp_n.delete();
    m_occ = 0;
    m_banks = 0;
    m_ready = 1'b1;
    m_ovf = 1'b0;
  endtask

  // Check outputs against the model, then advance the model over the edge
  task automatic model_step();
    bit rel;
    bit cmt;
    rel = 1'b0;
    cmt = 1'b0;
    chk("wr_ready", 64'(wr_ready), 64'(m_ready));
    chk("banks_ready", 64'(banks_ready), 64'(m_banks));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("wr_afull", 64'(wr_afull), 64'(open_q.size() >= DEPTH - 1));
    if (rd_valid && rd_en) begin
      if (exp_d.size() == 0) begin
        chk("unexpected_rd_valid", 64'(rd_valid), 64'(0));
      end else begin
        chk("rd_data", 64'(rd_data), 64'(exp_d[0]));
        chk("rd_last", 64'(rd_last), 64'(exp_l[0]));
        chk("rd_len", 64'(rd_len), 64'(exp_n[0]));
        rel = exp_l[0];
        void'(exp_d.pop_front());
        void'(exp_l.pop_front());
        void'(exp_n.pop_front());
      end
    end
    if (wr_en) begin
      if (m_ready) begin
        if (open_q.size() == 0) m_occ++;
        open_q.push_back(wr_data);
        if (open_q.size() == DEPTH) cmt = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (open_q.size() != 0) begin
      cmt = 1'b1;
    end
    if (cmt) begin
      foreach (open_q[i]) begin
        exp_d.push_back(open_q[i]);
        exp_l.push_back(i == open_q.size() - 1);
        exp_n.push_back(open_q.size());
      end
      open_q.delete();
      m_banks++;
    end
    if (rel) begin
      m_occ--;
      m_banks--;
    end
    m_ready = (open_q.size() != 0) || (m_occ < NB);
  endtask

  // One clock: drive, check at negedge, return 1 time unit after posedge
  task automatic cyc(input logic we, input logic [DW-1:0] wd,
                     input logic re);
    wr_en = we;
    wr_data = wd;
    rd_en = re;
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_wr_ready"}, 64'(wr_ready), 64'(1));
    chk({p, "_wr_afull"}, 64'(wr_afull), 64'(0));
    chk({p, "_rd_valid"}, 64'(rd_valid), 64'(0));
    chk({p, "_rd_last"}, 64'(rd_last), 64'(0));
    chk({p, "_rd_len"}, 64'(rd_len), 64'(0));
    chk({p, "_rd_data"}, 64'(rd_data), 64'(0));
    chk({p, "_banks_ready"}, 64'(banks_ready), 64'(0));
    chk({p, "_overflow"}, 64'(overflow), 64'(0));
  endtask

  // Asynchronous reset away from the clock edge
  task automatic apply_reset(input string p);
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_data = '0;
    #1;
    chk_reset_vals(p);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_d.size() != 0 || open_q.size() != 0 || rd_valid) && k < 300) begin
      cyc(1'b0, '0, 1'b1);
      k++;
    end
    chk("drain_complete", 64'(exp_d.size() + open_q.size()), 64'(0));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("init");
    reset = 1'b0;
    model_clear();

    // 5-word burst, reader always ready
    for (int i = 1; i <= 5; i++) cyc(1'b1, DW'(i), 1'b1);
    cyc(1'b0, '0, 1'b1);
    chk("t1_commit_banks", 64'(banks_ready), 64'(1));
    chk("t1_commit_valid", 64'(rd_valid), 64'(0));
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0, '0, 1'b1);
      chk("t1_valid", 64'(rd_valid), 64'(1));
      chk("t1_data", 64'(rd_data), 64'(i));
      chk("t1_len", 64'(rd_len), 64'(5));
      chk("t1_last", 64'(rd_last), 64'(i == 5));
    end
    cyc(1'b0, '0, 1'b1);
    chk("t1_end_valid", 64'(rd_valid), 64'(0));
    chk("t1_end_banks", 64'(banks_ready), 64'(0));

    // Two full banks with no reader, then an overflowing write
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, DW'(16'h100 + i), 1'b0);
      if (i == 6) chk("t2_afull", 64'(wr_afull), 64'(1));
      if (i == 7) begin
        chk("t2_bank1_cnt", 64'(banks_ready), 64'(1));
        chk("t2_ready_mid", 64'(wr_ready), 64'(1));
        chk("t2_afull_clr", 64'(wr_afull), 64'(0));
      end
    end
    chk("t2_banks_full", 64'(banks_ready), 64'(2));
    chk("t2_not_ready", 64'(wr_ready), 64'(0));
    cyc(1'b1, DW'(16'hdead), 1'b0);
    chk("t2_overflow", 64'(overflow), 64'(1));
    drain();

    // Bursts of 3 and 1 with one idle cycle between banks
    cyc(1'b1, DW'(16'h0a1), 1'b1);
    cyc(1'b1, DW'(16'h0a2), 1'b1);
    cyc(1'b1, DW'(16'h0a3), 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b1, DW'(16'h0b1), 1'b1);
    chk("t3_first_data", 64'(rd_data), 64'(16'h0a1));
    chk("t3_first_len", 64'(rd_len), 64'(3));
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    chk("t3_last_a", 64'(rd_last), 64'(1));
    cyc(1'b0, '0, 1'b1);
    chk("t3_gap", 64'(rd_valid), 64'(0));
    cyc(1'b0, '0, 1'b1);
    chk("t3_single_valid", 64'(rd_valid), 64'(1));
    chk("t3_single_last", 64'(rd_last), 64'(1));
    chk("t3_single_data", 64'(rd_data), 64'(16'h0b1));
    chk("t3_single_len", 64'(rd_len), 64'(1));
    cyc(1'b0, '0, 1'b1);
    chk("t3_end_valid", 64'(rd_valid), 64'(0));
    chk("t3_end_banks", 64'(banks_ready), 64'(0));

    // Reader stall mid-bank holds the head word
    for (int i = 0; i < 6; i++) cyc(1'b1, DW'(16'h200 + i), 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("t4_head", 64'(rd_data), 64'(16'h200));
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, '0, 1'b0);
      chk("t4_hold_data", 64'(rd_data), 64'(16'h202));
      chk("t4_hold_valid", 64'(rd_valid), 64'(1));
    end
    drain();

    // Reset mid-drain, then a fresh 2-word burst
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'(16'h400 + i), 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    chk("t6_mid_data", 64'(rd_data), 64'(16'h402));
    apply_reset("t6_rst");
    cyc(1'b1, DW'(16'h077), 1'b1);
    cyc(1'b1, DW'(16'h078), 1'b1);
    cyc(1'b0, '0, 1'b1);
    drain();

    // Both banks full; release coincides with the writer's retry
    apply_reset("t5_rst");
    for (int i = 0; i < 16; i++) cyc(1'b1, DW'(16'h300 + i), 1'b0);
    chk("t5_full_banks", 64'(banks_ready), 64'(2));
    chk("t5_full_ready", 64'(wr_ready), 64'(0));
    chk("t5_head", 64'(rd_data), 64'(16'h300));
    for (int i = 0; i < 7; i++) cyc(1'b0, '0, 1'b1);
    chk("t5_last_word", 64'(rd_last), 64'(1));
    cyc(1'b1, DW'(16'hbeef), 1'b1);
    chk("t5_ready_up", 64'(wr_ready), 64'(1));
    chk("t5_banks_rel", 64'(banks_ready), 64'(1));
    chk("t5_gap", 64'(rd_valid), 64'(0));
    cyc(1'b1, DW'(16'hbeef), 1'b1);
    chk("t5_bank1_head", 64'(rd_data), 64'(16'h308));
    chk("t5_banks_fill", 64'(banks_ready), 64'(1));
    cyc(1'b0, '0, 1'b1);
    chk("t5_banks_commit", 64'(banks_ready), 64'(2));
    drain();

    // Random traffic against the model
    for (int blk = 0; blk < 12; blk++) begin
      int wp;
      int rp;
      wp = int'($urandom_range(40, 100));
      rp = int'($urandom_range(10, 100));
      for (int c = 0; c < 120; c++) begin
        cyc(int'($urandom_range(0, 99)) < wp, DW'($urandom()),
            int'($urandom_range(0, 99)) < rp);
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
